// File: rtl/ssr_pkg.sv
// Shared definitions for the residential security system stages.
// Holds the siren FSM state encodings used by the RTL and the bench.
package ssr_pkg;

    typedef enum logic [1:0] {
        ST_REPOUSO = 2'b00,
        ST_ATRASO  = 2'b01,
        ST_DISPARO = 2'b10,
        ST_MEMORIA = 2'b11
    } estado_t;

endpackage

// File: rtl/divisor_modulacao.sv
// Siren modulation divider: a toggle bit with a modulo-MEIO_PERIODO counter.
// Load sets the bit high, enable advances it, otherwise it is cleared.
module divisor_modulacao #(
    parameter int MEIO_PERIODO = 4,
    parameter int LARG         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic habilita,
    input  logic carrega,
    output logic toggle
);

    localparam logic [LARG-1:0] TOPO = LARG'(MEIO_PERIODO - 1);
    localparam logic [LARG-1:0] UM   = LARG'(1);

    logic [LARG-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            toggle <= 1'b0;
        end else if (carrega) begin
            cnt    <= '0;
            toggle <= 1'b1;
        end else if (habilita) begin
            if (cnt == TOPO) begin
                cnt    <= '0;
                toggle <= ~toggle;
            end else begin
                cnt <= cnt + UM;
            end
        end else begin
            // Outside an active burst the siren stays silent and idle.
            cnt    <= '0;
            toggle <= 1'b0;
        end
    end

endmodule

// File: rtl/alarme_sirene.sv
// Siren stage: entry delay, bounded modulated burst and latched alarm memory.
// One shared down-counter times both the entry delay and the burst.
module alarme_sirene
    import ssr_pkg::*;
#(
    parameter int ATRASO       = 16,
    parameter int DURACAO      = 64,
    parameter int MEIO_PERIODO = 4,
    parameter int LARG         = 8
) (
    input  logic       gerador_frequencia,
    input  logic       reset_n,
    input  logic       alarme,
    input  logic       desarmar,
    output logic       sirene,
    output logic       luz,
    output logic       disparado,
    output logic [1:0] estado
);

    localparam logic [LARG-1:0] ATRASO_INI  = LARG'(ATRASO - 1);
    localparam logic [LARG-1:0] DURACAO_INI = LARG'(DURACAO - 1);
    localparam logic [LARG-1:0] UM          = LARG'(1);

    estado_t         st;
    estado_t         st_nxt;
    logic [LARG-1:0] cnt;
    logic [LARG-1:0] cnt_nxt;
    logic            carrega;
    logic            habilita;

    always_ff @(posedge gerador_frequencia or negedge reset_n) begin
        if (!reset_n) begin
            st        <= ST_REPOUSO;
            cnt       <= '0;
            luz       <= 1'b0;
            disparado <= 1'b0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            luz <= (st_nxt == ST_DISPARO);
            if (desarmar)
                disparado <= 1'b0;
            else if (st_nxt == ST_DISPARO)
                disparado <= 1'b1;
        end
    end

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        carrega = 1'b0;
        if (desarmar) begin
            st_nxt  = ST_REPOUSO;
            cnt_nxt = '0;
        end else begin
            case (st)
                ST_REPOUSO: begin
                    if (alarme) begin
                        st_nxt  = ST_ATRASO;
                        cnt_nxt = ATRASO_INI;
                    end
                end
                ST_ATRASO: begin
                    // The violation is latched: alarme dropping does not cancel.
                    if (cnt == '0) begin
                        st_nxt  = ST_DISPARO;
                        cnt_nxt = DURACAO_INI;
                        carrega = 1'b1;
                    end else begin
                        cnt_nxt = cnt - UM;
                    end
                end
                ST_DISPARO: begin
                    if (cnt == '0) begin
                        st_nxt  = ST_MEMORIA;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt - UM;
                    end
                end
                ST_MEMORIA: begin
                    if (alarme) begin
                        st_nxt  = ST_DISPARO;
                        cnt_nxt = DURACAO_INI;
                        carrega = 1'b1;
                    end
                end
                default: begin
                    st_nxt  = ST_REPOUSO;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    assign habilita = (st == ST_DISPARO) && (st_nxt == ST_DISPARO);
    assign estado   = st;

    divisor_modulacao #(
        .MEIO_PERIODO(MEIO_PERIODO),
        .LARG        (LARG)
    ) u_divisor (
        .clk     (gerador_frequencia),
        .rst_n   (reset_n),
        .habilita(habilita),
        .carrega (carrega),
        .toggle  (sirene)
    );

endmodule
